// File: rtl/snake_game_arcade_if.sv
// Player controls and debug/status outputs of the snake game, bundled for the top level.
interface snake_game_arcade_if;
  logic [3:0]  buttons;
  logic        start;
  logic        pause;
  logic        finished;
  logic        won;
  logic        lost;
  logic [6:0]  db_state;
  logic [6:0]  db_state2;
  logic [35:0] db_leds;
  logic [3:0]  db_size;

  modport master (
    output buttons, start, pause,
    input  finished, won, lost, db_state, db_state2, db_leds, db_size
  );

  modport slave (
    input  buttons, start, pause,
    output finished, won, lost, db_state, db_state2, db_leds, db_size
  );
endinterface

// File: rtl/snake_game_arcade.sv
// 6x6 snake game: FSM control, timed movement, LFSR apple placement, collision/win
// detection and a registered 36-bit LED frame.
module snake_game_arcade #(
  parameter int unsigned MOVE_TICKS = 16,
  parameter int unsigned MAX_SIZE   = 8
) (
  input logic               clock,
  input logic               restart,
  snake_game_arcade_if.slave bus
);
  localparam int unsigned CW = (MOVE_TICKS > 2) ? $clog2(MOVE_TICKS) : 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_INIT  = 4'd1, S_RUN = 4'd2, S_PAUSE = 4'd3, S_MOVE = 4'd4,
    S_CHECK = 4'd5, S_APPLE = 4'd6, S_WON = 4'd7, S_LOST  = 4'd8
  } state_t;

  state_t        r_state;
  logic [5:0]    r_body [MAX_SIZE];
  logic [3:0]    r_size;
  logic [1:0]    r_dir, r_pend;
  logic [5:0]    r_apple, r_lfsr;
  logic [CW-1:0] r_cnt;
  logic          r_grew, r_won, r_lost;
  logic [35:0]   r_leds;

  logic [1:0]  w_btn_dir;
  logic        w_btn_ok;
  logic [5:0]  w_row, w_col, w_next;
  logic        w_next_ok, w_hit_self, w_lfsr_busy;
  logic [35:0] w_frame;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  // Button priority up > down > left > right; a reverse of the current heading is ignored.
  always_comb begin
    w_btn_ok  = |bus.buttons;
    w_btn_dir = 2'd3;
    if (bus.buttons[0])      w_btn_dir = 2'd0;
    else if (bus.buttons[1]) w_btn_dir = 2'd1;
    else if (bus.buttons[2]) w_btn_dir = 2'd2;
    if (w_btn_dir == (r_dir ^ 2'd1)) w_btn_ok = 1'b0;
  end

  always_comb begin
    w_row     = r_body[0] / 6'd6;
    w_col     = r_body[0] % 6'd6;
    w_next    = r_body[0];
    w_next_ok = 1'b1;
    case (r_pend)
      2'd0:    if (w_row == 6'd0) w_next_ok = 1'b0; else w_next = r_body[0] - 6'd6;
      2'd1:    if (w_row == 6'd5) w_next_ok = 1'b0; else w_next = r_body[0] + 6'd6;
      2'd2:    if (w_col == 6'd0) w_next_ok = 1'b0; else w_next = r_body[0] - 6'd1;
      default: if (w_col == 6'd5) w_next_ok = 1'b0; else w_next = r_body[0] + 6'd1;
    endcase
  end

  always_comb begin
    w_hit_self  = 1'b0;
    w_lfsr_busy = 1'b0;
    w_frame     = '0;
    w_frame[r_apple] = 1'b1;
    for (int unsigned i = 0; i < MAX_SIZE; i++) begin
      if (i < 32'(r_size)) begin
        w_frame[r_body[i]] = 1'b1;
        if (r_body[i] == r_lfsr) w_lfsr_busy = 1'b1;
        if (i != 0 && r_body[i] == r_body[0]) w_hit_self = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      r_state <= S_IDLE;
      for (int unsigned i = 0; i < MAX_SIZE; i++) r_body[i] <= '0;
      r_body[0] <= 6'd14;
      r_body[1] <= 6'd13;
      r_size  <= 4'd2;
      r_dir   <= 2'd3;
      r_pend  <= 2'd3;
      r_apple <= 6'd16;
      r_cnt   <= '0;
      r_lfsr  <= 6'h2A;
      r_grew  <= 1'b0;
      r_won   <= 1'b0;
      r_lost  <= 1'b0;
      r_leds  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
      r_leds <= (r_state == S_IDLE) ? '0 : w_frame;
      case (r_state)
        S_IDLE: if (bus.start) r_state <= S_INIT;
        S_INIT: begin
          r_body[0] <= 6'd14;
          r_body[1] <= 6'd13;
          r_size  <= 4'd2;
          r_dir   <= 2'd3;
          r_pend  <= 2'd3;
          r_apple <= 6'd16;
          r_cnt   <= '0;
          r_grew  <= 1'b0;
          r_won   <= 1'b0;
          r_lost  <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_btn_ok) r_pend <= w_btn_dir;
          if (bus.pause) r_state <= S_PAUSE;
          else if (r_cnt == CW'(MOVE_TICKS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_MOVE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_PAUSE: begin
          if (w_btn_ok) r_pend <= w_btn_dir;
          if (!bus.pause) r_state <= S_RUN;
        end
        S_MOVE: begin
          r_dir <= r_pend;
          if (!w_next_ok) begin
            r_lost  <= 1'b1;
            r_state <= S_LOST;
          end else begin
            // The shift is identical for grow and plain moves; only the valid count differs.
            for (int unsigned i = 1; i < MAX_SIZE; i++) r_body[i] <= r_body[i-1];
            r_body[0] <= w_next;
            r_grew    <= (w_next == r_apple);
            if (w_next == r_apple) r_size <= r_size + 4'd1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_hit_self) begin
            r_lost  <= 1'b1;
            r_state <= S_LOST;
          end else if (r_grew && r_size == 4'(MAX_SIZE)) begin
            r_won   <= 1'b1;
            r_state <= S_WON;
          end else if (r_grew) r_state <= S_APPLE;
          else r_state <= S_RUN;
        end
        S_APPLE: if (r_lfsr < 6'd36 && !w_lfsr_busy) begin
          r_apple <= r_lfsr;
          r_state <= S_RUN;
        end
        S_WON, S_LOST: if (bus.start) r_state <= S_INIT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.won       = r_won;
  assign bus.lost      = r_lost;
  assign bus.finished  = r_won | r_lost;
  assign bus.db_state  = seg7(r_state);
  assign bus.db_state2 = seg7({2'b00, r_dir});
  assign bus.db_leds   = r_leds;
  assign bus.db_size   = r_size;
endmodule

// File: tb/tb_snake_game_arcade.sv
// Directed bench for snake_game_arcade: table-driven game walk plus apple, wall and reset sequences.
module tb_snake_game_arcade;
  logic clock = 1'b0;
  logic restart = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  snake_game_arcade_if sif ();

  snake_game_arcade #(.MOVE_TICKS(16), .MAX_SIZE(8)) dut (
    .clock(clock), .restart(restart), .bus(sif)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S8 = 7'h00;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  btn;
    logic        st;
    logic        pa;
    logic [6:0]  e_state;
    logic [6:0]  e_dir;
    logic [3:0]  e_size;
    logic [35:0] e_leds;
    logic        chk_leds;
    logic        e_fin;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [35:0] cells(input int unsigned a, input int unsigned b, input int unsigned c);
    logic [35:0] v;
    v = (36'd1 << a) | (36'd1 << b) | (36'd1 << c);
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [6:0] s, input int unsigned maxc, input string nm);
    int unsigned k;
    k = 0;
    while (sif.db_state !== s && k < maxc) begin
      step(1);
      k++;
    end
    checks++;
    if (sif.db_state !== s) begin
      errors++;
      $display("FAIL %s: state %h after %0d cycles, expected %h", nm, sif.db_state, k, s);
    end
  endtask

  initial begin
    logic [35:0] l;
    sif.buttons = '0;
    sif.start   = 1'b0;
    sif.pause   = 1'b0;

    vecs[0]  = '{2,   4'h0, 1'b0, 1'b0, S0, S3, 4'd2, 36'h0,            1'b1, 1'b0};
    vecs[1]  = '{1,   4'h0, 1'b1, 1'b0, S1, S3, 4'd2, 36'h0,            1'b1, 1'b0};
    vecs[2]  = '{1,   4'h0, 1'b0, 1'b0, S2, S3, 4'd2, cells(13, 14, 16), 1'b1, 1'b0};
    vecs[3]  = '{15,  4'h0, 1'b0, 1'b0, S2, S3, 4'd2, cells(13, 14, 16), 1'b1, 1'b0};
    vecs[4]  = '{1,   4'h4, 1'b0, 1'b0, S4, S3, 4'd2, cells(13, 14, 16), 1'b1, 1'b0};
    vecs[5]  = '{1,   4'h0, 1'b0, 1'b0, S5, S3, 4'd2, cells(13, 14, 16), 1'b1, 1'b0};
    vecs[6]  = '{1,   4'h0, 1'b0, 1'b0, S2, S3, 4'd2, cells(14, 15, 16), 1'b1, 1'b0};
    vecs[7]  = '{1,   4'h1, 1'b0, 1'b0, S2, S3, 4'd2, cells(14, 15, 16), 1'b1, 1'b0};
    vecs[8]  = '{15,  4'h0, 1'b0, 1'b0, S4, S3, 4'd2, cells(14, 15, 16), 1'b1, 1'b0};
    vecs[9]  = '{2,   4'h0, 1'b0, 1'b0, S2, S0, 4'd2, cells(9, 15, 16),  1'b1, 1'b0};
    vecs[10] = '{1,   4'h0, 1'b0, 1'b1, S3, S0, 4'd2, cells(9, 15, 16),  1'b1, 1'b0};
    vecs[11] = '{100, 4'h0, 1'b0, 1'b1, S3, S0, 4'd2, cells(9, 15, 16),  1'b1, 1'b0};
    vecs[12] = '{1,   4'h0, 1'b0, 1'b0, S2, S0, 4'd2, cells(9, 15, 16),  1'b1, 1'b0};
    vecs[13] = '{15,  4'h0, 1'b0, 1'b0, S2, S0, 4'd2, cells(9, 15, 16),  1'b1, 1'b0};
    vecs[14] = '{1,   4'h0, 1'b0, 1'b0, S4, S0, 4'd2, cells(9, 15, 16),  1'b1, 1'b0};
    vecs[15] = '{2,   4'h0, 1'b0, 1'b0, S2, S0, 4'd2, cells(3, 9, 16),   1'b1, 1'b0};
    vecs[16] = '{17,  4'h0, 1'b0, 1'b0, S8, S0, 4'd2, cells(3, 9, 16),   1'b1, 1'b1};
    vecs[17] = '{20,  4'h0, 1'b0, 1'b0, S8, S0, 4'd2, cells(3, 9, 16),   1'b1, 1'b1};
    vecs[18] = '{1,   4'h0, 1'b1, 1'b0, S1, S0, 4'd2, cells(3, 9, 16),   1'b1, 1'b1};
    vecs[19] = '{1,   4'h0, 1'b0, 1'b0, S2, S3, 4'd2, 36'h0,            1'b0, 1'b0};
    vecs[20] = '{1,   4'h0, 1'b0, 1'b0, S2, S3, 4'd2, cells(13, 14, 16), 1'b1, 1'b0};

    step(3);
    restart = 1'b1;

    for (int i = 0; i < 21; i++) begin
      sif.buttons = vecs[i].btn;
      sif.start   = vecs[i].st;
      sif.pause   = vecs[i].pa;
      step(vecs[i].cyc);
      check($sformatf("v%0d_state", i), 64'(sif.db_state), 64'(vecs[i].e_state));
      check($sformatf("v%0d_dir", i), 64'(sif.db_state2), 64'(vecs[i].e_dir));
      check($sformatf("v%0d_size", i), 64'(sif.db_size), 64'(vecs[i].e_size));
      check($sformatf("v%0d_fin", i), 64'(sif.finished), 64'(vecs[i].e_fin));
      if (vecs[i].chk_leds) check($sformatf("v%0d_leds", i), 64'(sif.db_leds), 64'(vecs[i].e_leds));
    end
    sif.buttons = '0;
    sif.start   = 1'b0;
    sif.pause   = 1'b0;

    // Eat the first apple: start edge, then 36 edges to the growing MOVE edge.
    restart = 1'b0;
    step(2);
    restart = 1'b1;
    step(2);
    sif.start = 1'b1;
    step(1);
    sif.start = 1'b0;
    step(35);
    check("pre_eat_size", 64'(sif.db_size), 64'd2);
    step(1);
    check("eat_size", 64'(sif.db_size), 64'd3);
    check("eat_state", 64'(sif.db_state), 64'(S5));
    step(1);
    check("apple_state", 64'(sif.db_state), 64'(S6));
    wait_state(S2, 100, "apple_placed");
    step(1);
    l = sif.db_leds;
    check("snake_cells", 64'(l & cells(14, 15, 16)), 64'(cells(14, 15, 16)));
    check("frame_count", 64'($countones(l)), 64'd4);
    check("won_low", 64'(sif.won), 64'd0);

    // Asynchronous reset mid-run, between clock edges.
    step(3);
    #3;
    restart = 1'b0;
    #1;
    check("arst_state", 64'(sif.db_state), 64'(S0));
    check("arst_size", 64'(sif.db_size), 64'd2);
    check("arst_leds", 64'(sif.db_leds), 64'd0);
    check("arst_dir", 64'(sif.db_state2), 64'(S3));
    step(1);
    restart = 1'b1;
    step(1);

    // Replay and run right into the east wall.
    sif.start = 1'b1;
    step(1);
    sif.start = 1'b0;
    step(2);
    check("replay_leds", 64'(sif.db_leds), 64'(cells(13, 14, 16)));
    wait_state(S8, 300, "wall_lost");
    check("wall_lost_flag", 64'(sif.lost), 64'd1);
    check("wall_finished", 64'(sif.finished), 64'd1);
    check("wall_won", 64'(sif.won), 64'd0);
    step(5);
    check("lost_hold", 64'(sif.db_state), 64'(S8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
